fb_wb_arbiter: RTL

- Shares the single register-file write port between two writeback sources.
  - Source A: in-order pipeline writeback. Highest priority, stallable.
  - Source B: long-latency unit (load/mul/div). Valid/ready, buffered in a small FIFO.
- Drives the register file's we/waddr/wdata from a registered stage.
- Exports a pending-destination bitmap for hazard detection.
- Provides a drain handshake for fence/CSR sequencing.

---
 rtl/fb_wb_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/fb_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between the
// in-order pipeline (A) and a FIFO-buffered long-latency unit (B).
module fb_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  output logic        a_stall,
  input  logic        b_valid,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        b_ready,
  input  logic        drain_req,
  output logic        drain_done,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {NORMAL, DRAIN} state_t;
  typedef enum logic [1:0] {G_NONE, G_A, G_B} grant_t;

  state_t state, state_d;
  grant_t grant;

  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [SW-1:0] starve_cnt;

  logic ne, a_ok, push, pop, starved;

  assign ne      = count != '0;
  assign b_ready = count != (PW+1)'(DEPTH);
  assign a_ok    = a_valid & (a_waddr != 5'd0);
  assign push    = b_valid & b_ready & (b_waddr != 5'd0);
  assign starved = starve_cnt == SW'(STARVE_LIMIT);
  assign pop     = grant == G_B;
  assign a_stall = a_ok & (grant != G_A);

  always_comb begin
    state_d = state;
    grant   = G_NONE;
    unique case (state)
      NORMAL: if (drain_req) state_d = DRAIN;
      DRAIN:  if (!drain_req) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
    // A is never granted while draining, so the FIFO can empty
    if (state == DRAIN && ne)       grant = G_B;
    else if (starved && ne)         grant = G_B;
    else if (a_ok && state == NORMAL) grant = G_A;
    else if (ne)                    grant = G_B;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= b_waddr;
      q_data[wr_ptr] <= b_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= NORMAL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      drain_done <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (!ne || pop)    starve_cnt <= '0;
      else if (!starved) starve_cnt <= starve_cnt + 1'b1;
      drain_done <= (state == DRAIN) & drain_req & !ne & !push & !rf_we;
      unique case (grant)
        G_A: begin
          rf_we    <= 1'b1;
          rf_waddr <= a_waddr;
          rf_wdata <= a_wdata;
        end
        G_B: begin
          rf_we    <= 1'b1;
          rf_waddr <= q_addr[rd_ptr];
          rf_wdata <= q_data[rd_ptr];
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

  always_comb begin : busy_map
    logic [PW-1:0] off;
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ({1'b0, off} < count) busy[q_addr[i]] = 1'b1;
    end
    if (rf_we) busy[rf_waddr] = 1'b1;
    busy[0] = 1'b0;
  end

endmodule
